// File: rtl/wdt_ctrl.sv
// System-clock-side watchdog controller: bus registers, stretched kick pulses, WTO sync and irq.
// Optional feature: define WDT_LOCK_EN to require a KEY unlock before CTRL/TOCNT writes.
module wdt_ctrl #(
   parameter int unsigned HOLD_CYC  = 4,
   parameter logic [31:0] TOCNT_RST = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [2:0]  req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        WDEN_o,
   output logic        WDLIVE_o,
   output logic [31:0] WTOCNT_o,
   input  logic        WTO_i,
   output logic        irq_o
);

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_LIVE   = 3'd1;
   localparam logic [2:0] A_TOCNT  = 3'd2;
   localparam logic [2:0] A_STATUS = 3'd3;
   localparam logic [2:0] A_KEY    = 3'd4;
   localparam logic [7:0] CNT_RELOAD = 8'(HOLD_CYC - 1);

   typedef enum logic [1:0] {K_IDLE, K_HOLD, K_GAP} kick_state_e;

   kick_state_e kick_state_q;
   logic [7:0]  kick_cnt_q;
   logic        pending_q, wdlive_q;

   logic        en_q, en_d, ie_q, ie_d;
   logic [31:0] tocnt_q, tocnt_d;
   logic        to_q, to_d, irq_q, wden_q;
   logic        rsp_valid_q, rsp_err_q;
   logic [31:0] rsp_rdata_q;
   logic [2:0]  wto_sync_q;

   logic        accept, kick_req, clr_to, wto_rise, busy, cfg_ok, err;
   logic [31:0] rd_data;

`ifdef WDT_LOCK_EN
   localparam logic [31:0] KEY_VALUE = 32'h5A5A_1234;
   logic unlocked_q, unlocked_d;
   assign cfg_ok = unlocked_q;
`else
   assign cfg_ok = 1'b1;
`endif

   // Ready drops during the response cycle, so at most one request is outstanding.
   assign req_ready_o = ~rsp_valid_q;
   assign accept      = req_valid_i & req_ready_o;
   assign busy        = (kick_state_q != K_IDLE);
   assign wto_rise    = wto_sync_q[1] & ~wto_sync_q[2];

   always_comb begin
      en_d     = en_q;
      ie_d     = ie_q;
      tocnt_d  = tocnt_q;
      clr_to   = 1'b0;
      kick_req = 1'b0;
      rd_data  = '0;
      err      = 1'b0;
`ifdef WDT_LOCK_EN
      unlocked_d = unlocked_q;
`endif
      if (accept) begin
         case (req_addr_i)
            A_CTRL: begin
               if (!req_write_i)  rd_data = {30'b0, ie_q, en_q};
               else if (cfg_ok)   {ie_d, en_d} = req_wdata_i[1:0];
               else               err = 1'b1;
            end
            A_LIVE:  kick_req = req_write_i & en_q;
            A_TOCNT: begin
               if (!req_write_i)           rd_data = tocnt_q;
               else if (!cfg_ok || en_q)   err = 1'b1;
               else                        tocnt_d = req_wdata_i;
            end
            A_STATUS: begin
               if (req_write_i) clr_to = req_wdata_i[0];
               else             rd_data = {30'b0, busy, to_q};
            end
`ifdef WDT_LOCK_EN
            A_KEY: if (!req_write_i) rd_data = {31'b0, unlocked_q};
`endif
            default: err = 1'b1;
         endcase
`ifdef WDT_LOCK_EN
         if (req_write_i)
            unlocked_d = (req_addr_i == A_KEY) && (req_wdata_i == KEY_VALUE);
`endif
      end
      // A new edge wins over a same-cycle clear.
      to_d = wto_rise | (to_q & ~clr_to);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q        <= 1'b0;
         ie_q        <= 1'b0;
         tocnt_q     <= TOCNT_RST;
         to_q        <= 1'b0;
         irq_q       <= 1'b0;
         wden_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         wto_sync_q  <= '0;
`ifdef WDT_LOCK_EN
         unlocked_q  <= 1'b0;
`endif
      end else begin
         en_q        <= en_d;
         ie_q        <= ie_d;
         tocnt_q     <= tocnt_d;
         to_q        <= to_d;
         irq_q       <= to_q & ie_q;
         wden_q      <= en_q;
         rsp_valid_q <= accept;
         rsp_err_q   <= err;
         rsp_rdata_q <= rd_data;
         wto_sync_q  <= {wto_sync_q[1:0], WTO_i};
`ifdef WDT_LOCK_EN
         unlocked_q  <= unlocked_d;
`endif
      end
   end

   // Kick FSM: a back-to-back pending kick re-enters HOLD straight from the end of GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kick_state_q <= K_IDLE;
         kick_cnt_q   <= '0;
         pending_q    <= 1'b0;
         wdlive_q     <= 1'b0;
      end else begin
         case (kick_state_q)
            K_IDLE: begin
               if (kick_req || (pending_q && en_q)) begin
                  kick_state_q <= K_HOLD;
                  wdlive_q     <= 1'b1;
                  kick_cnt_q   <= CNT_RELOAD;
                  pending_q    <= 1'b0;
               end
            end
            K_HOLD: begin
               if (kick_req) pending_q <= 1'b1;
               if (kick_cnt_q == 8'd0) begin
                  kick_state_q <= K_GAP;
                  wdlive_q     <= 1'b0;
                  kick_cnt_q   <= CNT_RELOAD;
               end else begin
                  kick_cnt_q   <= kick_cnt_q - 8'd1;
               end
            end
            K_GAP: begin
               if (kick_cnt_q == 8'd0) begin
                  if (kick_req || (pending_q && en_q)) begin
                     kick_state_q <= K_HOLD;
                     wdlive_q     <= 1'b1;
                     kick_cnt_q   <= CNT_RELOAD;
                     pending_q    <= 1'b0;
                  end else begin
                     kick_state_q <= K_IDLE;
                  end
               end else begin
                  kick_cnt_q <= kick_cnt_q - 8'd1;
                  if (kick_req) pending_q <= 1'b1;
               end
            end
            default: begin
               kick_state_q <= K_IDLE;
               wdlive_q     <= 1'b0;
            end
         endcase
         if (!en_q) pending_q <= 1'b0;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign WDEN_o      = wden_q;
   assign WDLIVE_o    = wdlive_q;
   assign WTOCNT_o    = tocnt_q;
   assign irq_o       = irq_q;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Scoreboard bench for wdt_ctrl: bus responses queued at issue, checked when rsp_valid fires.
module tb_wdt_ctrl;

   localparam int unsigned HOLD_CYC = 4;
   localparam logic [2:0] A_CTRL = 3'd0, A_LIVE = 3'd1, A_TOCNT = 3'd2,
                          A_STATUS = 3'd3, A_KEY = 3'd4;
   localparam logic [31:0] KEY_VALUE = 32'h5A5A_1234;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i, req_ready_o, req_write_i;
   logic [2:0]  req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        WDEN_o, WDLIVE_o, WTO_i, irq_o;
   logic [31:0] WTOCNT_o;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       tag;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   logic      live_hist[$];
   bit        live_rec = 1'b0;
   int        checks = 0;
   int        errors = 0;
   int        txn_cnt = 0;

   wdt_ctrl #(.HOLD_CYC(HOLD_CYC), .TOCNT_RST(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .WDEN_o(WDEN_o), .WDLIVE_o(WDLIVE_o), .WTOCNT_o(WTOCNT_o),
      .WTO_i(WTO_i), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rsp_valid_o) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_unexpected", 32'(sb_q.size()), 32'd1);
         end else begin
            sb_entry_t e;
            e = sb_q.pop_front();
            txn_cnt++;
            $display("txn %0d %s rdata=%h err=%b", txn_cnt, e.tag, rsp_rdata_o, rsp_err_o);
            check_eq({e.tag, "_rdata"}, rsp_rdata_o, e.rdata);
            check_eq({e.tag, "_err"}, {31'b0, rsp_err_o}, {31'b0, e.err});
         end
      end
   end

   always @(negedge clk) if (live_rec) live_hist.push_back(WDLIVE_o);

   task automatic bus_req(input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input string tag);
      int waited = 0;
      sb_entry_t e;
      while (!req_ready_o && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!req_ready_o) begin
         check_eq({tag, "_ready"}, {31'b0, req_ready_o}, 32'd1);
         return;
      end
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.tag   = tag;
      sb_q.push_back(e);
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      check_eq({tag, "_lat"}, {31'b0, rsp_valid_o}, 32'd1);
   endtask

   task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data,
                            input logic exp_err, input string tag);
`ifdef WDT_LOCK_EN
      bus_req(1'b1, A_KEY, KEY_VALUE, 32'd0, 1'b0, {tag, "_key"});
`endif
      bus_req(1'b1, addr, data, 32'd0, exp_err, tag);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic check_kick(input int exp_pulses, input string tag);
      int   pulses = 0;
      int   run = 0;
      int   low_run = 0;
      bit   seen = 1'b0;
      logic prev = 1'b0;
      int   highs[$];
      int   lows[$];
      foreach (live_hist[i]) begin
         if (live_hist[i]) begin
            if (!prev) begin
               pulses++;
               if (seen) lows.push_back(low_run);
            end
            run++;
         end else begin
            if (prev) begin
               highs.push_back(run);
               run = 0;
               low_run = 0;
               seen = 1'b1;
            end
            low_run++;
         end
         prev = live_hist[i];
      end
      if (prev) highs.push_back(run);
      check_eq({tag, "_pulses"}, pulses, exp_pulses);
      foreach (highs[i]) check_eq({tag, "_high"}, highs[i], HOLD_CYC);
      foreach (lows[i])  check_eq({tag, "_gap"}, lows[i], HOLD_CYC);
      live_hist.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
      WTO_i = 1'b0;
      cycles(3);
      check_eq("rst_ready", {31'b0, req_ready_o}, 32'd1);
      check_eq("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
      check_eq("rst_rdata", rsp_rdata_o, 32'd0);
      check_eq("rst_err", {31'b0, rsp_err_o}, 32'd0);
      check_eq("rst_wden", {31'b0, WDEN_o}, 32'd0);
      check_eq("rst_wdlive", {31'b0, WDLIVE_o}, 32'd0);
      check_eq("rst_wtocnt", WTOCNT_o, 32'hFFFF_FFFF);
      check_eq("rst_irq", {31'b0, irq_o}, 32'd0);
      rst_n = 1'b1;
      cycles(2);

      // Register reads after reset
      bus_req(1'b0, A_CTRL,   0, 32'd0,         1'b0, "rd_ctrl");
      bus_req(1'b0, A_LIVE,   0, 32'd0,         1'b0, "rd_live");
      bus_req(1'b0, A_TOCNT,  0, 32'hFFFF_FFFF, 1'b0, "rd_tocnt");
      bus_req(1'b0, A_STATUS, 0, 32'd0,         1'b0, "rd_status");
      bus_req(1'b0, 3'd5,     0, 32'd0,         1'b1, "rd_addr5");
`ifdef WDT_LOCK_EN
      bus_req(1'b0, A_KEY, 0, 32'd0, 1'b0, "rd_key");
      bus_req(1'b1, A_CTRL, 32'd1, 32'd0, 1'b1, "ctrl_locked");
      cycles(2);
      check_eq("locked_wden", {31'b0, WDEN_o}, 32'd0);
      bus_req(1'b1, A_KEY, KEY_VALUE, 32'd0, 1'b0, "key_unlock");
      bus_req(1'b0, A_KEY, 0, 32'd1, 1'b0, "rd_key_open");
      bus_req(1'b1, A_CTRL, 32'd1, 32'd0, 1'b0, "ctrl_unlocked");
      bus_req(1'b0, A_KEY, 0, 32'd0, 1'b0, "rd_key_relocked");
      check_eq("unlocked_wden", {31'b0, WDEN_o}, 32'd1);
      bus_req(1'b1, A_KEY, 32'h1234_5678, 32'd0, 1'b0, "key_wrong");
      cfg_write(A_CTRL, 32'd0, 1'b0, "ctrl_off");
`else
      bus_req(1'b0, A_KEY, 0, 32'd0, 1'b1, "rd_key_unmapped");
      bus_req(1'b1, A_KEY, KEY_VALUE, 32'd0, 1'b1, "wr_key_unmapped");
`endif

      // TOCNT update and lock-out while enabled
      cfg_write(A_TOCNT, 32'd1000, 1'b0, "wr_tocnt");
      check_eq("wtocnt_1000", WTOCNT_o, 32'd1000);
      cfg_write(A_CTRL, 32'd3, 1'b0, "wr_ctrl3");
      check_eq("wden_resp_cycle", {31'b0, WDEN_o}, 32'd0);
      cycles(1);
      check_eq("wden_after", {31'b0, WDEN_o}, 32'd1);
      cfg_write(A_TOCNT, 32'd5, 1'b1, "wr_tocnt_en");
      check_eq("wtocnt_kept", WTOCNT_o, 32'd1000);
      bus_req(1'b0, A_CTRL, 0, 32'd3, 1'b0, "rd_ctrl3");

      // Three back-to-back kicks merge into two pulses
      live_rec = 1'b1;
      bus_req(1'b1, A_LIVE, 32'd1, 32'd0, 1'b0, "kick0");
      bus_req(1'b1, A_LIVE, 32'd2, 32'd0, 1'b0, "kick1");
      bus_req(1'b1, A_LIVE, 32'd3, 32'd0, 1'b0, "kick2");
      bus_req(1'b0, A_STATUS, 0, 32'd2, 1'b0, "rd_busy");
      cycles(30);
      live_rec = 1'b0;
      check_kick(2, "merge");
      bus_req(1'b0, A_STATUS, 0, 32'd0, 1'b0, "rd_idle");

      // Timeout path
      #2 WTO_i = 1'b1;
      @(posedge clk); #1;
      cycles(2);
      check_eq("irq_pre", {31'b0, irq_o}, 32'd0);
      cycles(1);
      check_eq("irq_set", {31'b0, irq_o}, 32'd1);
      bus_req(1'b0, A_STATUS, 0, 32'd1, 1'b0, "rd_to");
      bus_req(1'b1, A_STATUS, 32'd1, 32'd0, 1'b0, "w1c_to");
      cycles(1);
      check_eq("irq_cleared", {31'b0, irq_o}, 32'd0);
      bus_req(1'b0, A_STATUS, 0, 32'd0, 1'b0, "rd_to_held");
      cycles(5);
      bus_req(1'b0, A_STATUS, 0, 32'd0, 1'b0, "rd_to_held2");
      WTO_i = 1'b0;
      cycles(4);
      bus_req(1'b0, A_STATUS, 0, 32'd0, 1'b0, "rd_to_low");
      #2 WTO_i = 1'b1;
      cycles(5);
      bus_req(1'b0, A_STATUS, 0, 32'd1, 1'b0, "rd_to_again");
      check_eq("irq_again", {31'b0, irq_o}, 32'd1);
      WTO_i = 1'b0;
      bus_req(1'b1, A_STATUS, 32'd1, 32'd0, 1'b0, "w1c_to2");

      // Unmapped address, then a kick while disabled
      bus_req(1'b0, 3'd6, 0, 32'd0, 1'b1, "rd_addr6");
      bus_req(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd0, 1'b1, "wr_addr6");
      cfg_write(A_CTRL, 32'd0, 1'b0, "ctrl_dis");
      live_rec = 1'b1;
      bus_req(1'b1, A_LIVE, 32'd1, 32'd0, 1'b0, "kick_dis");
      cycles(12);
      live_rec = 1'b0;
      check_kick(0, "dis");
      check_eq("irq_off", {31'b0, irq_o}, 32'd0);

      // Clearing EN mid-kick drops the pending kick
      cfg_write(A_CTRL, 32'd1, 1'b0, "ctrl_en");
      live_rec = 1'b1;
      bus_req(1'b1, A_LIVE, 32'd1, 32'd0, 1'b0, "kick_a");
      bus_req(1'b1, A_LIVE, 32'd1, 32'd0, 1'b0, "kick_b");
      cfg_write(A_CTRL, 32'd0, 1'b0, "ctrl_midoff");
      cycles(25);
      live_rec = 1'b0;
      check_kick(1, "midoff");

      cycles(3);
      check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
